// File: rtl/program_loader.sv
// Boot-time loader: receives a framed, checksummed byte stream, writes the image
// to memory, then releases the processor and passes the memory port through.
`timescale 1ns/1ps
module program_loader #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rxData,
  input  logic             rxValid,
  output logic             rxReady,
  input  logic             cpuMemRead,
  input  logic             cpuMemWrite,
  input  logic [WIDTH-1:0] cpuAdr,
  input  logic [WIDTH-1:0] cpuData,
  output logic             memRead,
  output logic             memWrite,
  output logic [WIDTH-1:0] memAdr,
  output logic [WIDTH-1:0] memData,
  output logic             cpuReset,
  output logic [WIDTH-1:0] loadedAdr,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    HDR_BASE,
    HDR_ENTRY,
    HDR_COUNT,
    PAYLOAD,
    CHECK,
    RUN,
    ERROR
  } state_t;

  state_t           state, state_next;
  logic             armed;
  logic             phase;
  logic [7:0]       hi_byte;
  logic [WIDTH-1:0] base, entry, remaining, index, sum;
  logic             wr_pulse;
  logic [WIDTH-1:0] wr_adr, wr_data;
  logic             loading, accept, word_done;
  logic [WIDTH-1:0] word;

  // armed keeps rxReady low until the first edge after reset is released
  assign loading   = (state != RUN) && (state != ERROR);
  assign rxReady   = armed & loading;
  assign accept    = rxValid & rxReady;
  assign word_done = accept & phase;
  assign word      = {hi_byte, rxData};
  assign loadedAdr = entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HDR_BASE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    memRead    = 1'b0;
    memWrite   = wr_pulse;
    memAdr     = wr_adr;
    memData    = wr_data;
    cpuReset   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      HDR_BASE:  if (word_done) state_next = HDR_ENTRY;
      HDR_ENTRY: if (word_done) state_next = HDR_COUNT;
      HDR_COUNT: if (word_done) state_next = (word == '0) ? CHECK : PAYLOAD;
      PAYLOAD:   if (word_done && remaining == WIDTH'(1)) state_next = CHECK;
      CHECK:     if (word_done) state_next = (word == sum) ? RUN : ERROR;
      RUN: begin
        memRead  = cpuMemRead;
        memWrite = cpuMemWrite;
        memAdr   = cpuAdr;
        memData  = cpuData;
        cpuReset = 1'b0;
        done     = 1'b1;
      end
      ERROR: begin
        memWrite = 1'b0;
        error    = 1'b1;
      end
      default: state_next = HDR_BASE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed     <= 1'b0;
      phase     <= 1'b0;
      hi_byte   <= '0;
      base      <= '0;
      entry     <= '0;
      remaining <= '0;
      index     <= '0;
      sum       <= '0;
      wr_pulse  <= 1'b0;
      wr_adr    <= '0;
      wr_data   <= '0;
    end else begin
      armed    <= 1'b1;
      wr_pulse <= 1'b0;
      if (accept) begin
        if (!phase) begin
          hi_byte <= rxData;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
        end
      end
      if (word_done) begin
        case (state)
          HDR_BASE:  base  <= word;
          HDR_ENTRY: entry <= word;
          HDR_COUNT: begin
            remaining <= word;
            index     <= '0;
            sum       <= '0;
          end
          PAYLOAD: begin
            wr_pulse  <= 1'b1;
            wr_adr    <= base + index;
            wr_data   <= word;
            sum       <= sum + word;
            index     <= index + WIDTH'(1);
            remaining <= remaining - WIDTH'(1);
          end
          default: ;
        endcase
      end
      if (state_next != state) phase <= 1'b0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rxData = '0;
  logic        rxValid = 1'b0;
  logic        rxReady;
  logic        cpuMemRead = 1'b0, cpuMemWrite = 1'b0;
  logic [15:0] cpuAdr = '0, cpuData = '0;
  logic        memRead, memWrite;
  logic [15:0] memAdr, memData, loadedAdr;
  logic        cpuReset, done, error;

  int          checks = 0;
  int          errors = 0;
  logic        log_en = 1'b0;
  logic        bad_read = 1'b0;
  logic [31:0] obs_q[$];
  logic [15:0] pl[$];

  program_loader #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .cpuMemRead(cpuMemRead), .cpuMemWrite(cpuMemWrite),
    .cpuAdr(cpuAdr), .cpuData(cpuData),
    .memRead(memRead), .memWrite(memWrite),
    .memAdr(memAdr), .memData(memData),
    .cpuReset(cpuReset), .loadedAdr(loadedAdr),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Log every cycle the loader drives a write while it owns the memory port
  always @(negedge clk) begin
    if (log_en && !done) begin
      if (memWrite) obs_q.push_back({memAdr, memData});
      if (memRead) bad_read = 1'b1;
    end
  end

  task automatic drive_cpu_noise();
    cpuMemRead  = 1'($urandom);
    cpuMemWrite = 1'($urandom);
    cpuAdr      = 16'($urandom);
    cpuData     = 16'($urandom);
  endtask

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(0, 2)) : g;
  endfunction

  function automatic logic [15:0] model_sum();
    logic [15:0] s;
    s = '0;
    foreach (pl[i]) s = s + pl[i];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      drive_cpu_noise();
    end
    expect_eq("rx_ready", 48'(rxReady), 48'(1));
    rxData  = b;
    rxValid = 1'b1;
    drive_cpu_noise();
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int g);
    send_byte(w[15:8], pick_gap(g));
    send_byte(w[7:0], pick_gap(g));
  endtask

  task automatic do_reset();
    #3 reset = 1'b0;
    drive_cpu_noise();
    #1;
    expect_eq("rst_ctrl", 48'({rxReady, memRead, memWrite, cpuReset, done, error}), 48'(6'b000100));
    expect_eq("rst_data", {memAdr, memData, loadedAdr}, 48'h0);
    @(negedge clk);
    drive_cpu_noise();
    @(negedge clk);
    expect_eq("rst_ctrl_hold", 48'({rxReady, memRead, memWrite, cpuReset, done, error}), 48'(6'b000100));
    expect_eq("rst_data_hold", {memAdr, memData, loadedAdr}, 48'h0);
    reset = 1'b1;
    #1 expect_eq("ready_pre_edge", 48'(rxReady), 48'(0));
    @(negedge clk);
    expect_eq("ready_post_edge", 48'(rxReady), 48'(1));
  endtask

  task automatic load_frame(input logic [15:0] base, input logic [15:0] entry,
                            input logic [15:0] sum, input int g);
    logic ok;
    int   nwr;
    ok = (sum == model_sum());
    obs_q.delete();
    bad_read = 1'b0;
    log_en   = 1'b1;
    send_word(base, g);
    send_word(entry, g);
    expect_eq("entry_adr", 48'(loadedAdr), 48'(entry));
    send_word(16'(pl.size()), g);
    foreach (pl[i]) begin
      send_word(pl[i], g);
      expect_eq("wr_now", 48'({memWrite, memAdr, memData}), 48'({1'b1, base + 16'(i), pl[i]}));
    end
    expect_eq("pre_sum", 48'({done, error, cpuReset, rxReady}), 48'(4'b0011));
    send_word(sum, g);
    expect_eq("result", 48'({done, error, cpuReset, rxReady}), ok ? 48'(4'b1000) : 48'(4'b0110));
    expect_eq("loaded_adr", 48'(loadedAdr), 48'(entry));
    repeat (2) @(negedge clk);
    expect_eq("wr_count", 48'(obs_q.size()), 48'(pl.size()));
    for (int i = 0; i < pl.size() && i < obs_q.size(); i++)
      expect_eq("wr_log", 48'(obs_q[i]), 48'({base + 16'(i), pl[i]}));
    expect_eq("no_read", 48'(bad_read), 48'(0));
    if (!ok) begin
      nwr = obs_q.size();
      for (int i = 0; i < 6; i++) begin
        rxValid = 1'b1;
        rxData  = 8'($urandom);
        drive_cpu_noise();
        @(negedge clk);
      end
      rxValid = 1'b0;
      expect_eq("err_hold", 48'({done, error, cpuReset, rxReady, memWrite, memRead}), 48'(6'b011000));
      expect_eq("err_nowr", 48'(obs_q.size()), 48'(nwr));
      expect_eq("err_adr", 48'(loadedAdr), 48'(entry));
    end
    log_en = 1'b0;
  endtask

  task automatic set_nominal();
    pl.delete();
    pl.push_back(16'h1234);
    pl.push_back(16'hABCD);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rs;
    int          n;
    do_reset();

    set_nominal();
    load_frame(16'h0100, 16'h0102, 16'hBE01, -1);

    // passthrough in RUN, same-cycle
    cpuMemRead = 1'b1; cpuMemWrite = 1'b0; cpuAdr = 16'h0040; cpuData = 16'h0000;
    #1 expect_eq("pass_read", 48'({memRead, memWrite, memAdr}), 48'({1'b1, 1'b0, 16'h0040}));
    cpuMemRead = 1'b0; cpuMemWrite = 1'b1; cpuData = 16'h5A5A;
    rxValid = 1'b1; rxData = 8'h01;
    #1 expect_eq("pass_write", 48'({memRead, memWrite, memData}), 48'({1'b0, 1'b1, 16'h5A5A}));
    repeat (4) @(negedge clk);
    rxValid = 1'b0;
    expect_eq("run_hold", 48'({done, error, cpuReset, rxReady, loadedAdr}), 48'({4'b1000, 16'h0102}));

    do_reset();
    set_nominal();
    load_frame(16'h0100, 16'h0102, 16'hBE00, -1);

    do_reset();
    pl.delete();
    load_frame(16'h0200, 16'h0200, 16'h0000, -1);

    do_reset();
    pl.delete();
    pl.push_back(16'hFFFF);
    pl.push_back(16'h0002);
    load_frame(16'hFFFF, 16'h0010, 16'h0001, -1);

    do_reset();
    set_nominal();
    load_frame(16'h0100, 16'h0102, 16'hBE01, 3);

    // reset mid-payload, then a clean reload
    do_reset();
    set_nominal();
    send_word(16'h0100, -1);
    send_word(16'h0102, -1);
    send_word(16'h0002, -1);
    send_word(16'h1234, -1);
    do_reset();
    load_frame(16'h0100, 16'h0102, 16'hBE01, -1);

    for (int f = 0; f < 8; f++) begin
      do_reset();
      pl.delete();
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) pl.push_back(16'($urandom));
      rs = model_sum();
      if ($urandom_range(0, 3) == 0) rs = rs ^ 16'($urandom_range(1, 65535));
      load_frame(16'($urandom), 16'($urandom), rs, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
